// File: rtl/table_writer.sv
// 16x4 (parameterisable) table with a self-initialising default fill (~address),
// a sequential valid/ready write port and a registered read-before-write read port.
module table_writer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_ptr
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_fill;
  logic [ADDR_W-1:0] w_inv_ptr;
  logic              w_last;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Invert at address width first, then fit to the data width.
  assign w_inv_ptr = ~r_wr_ptr;
  if (DATA_W <= ADDR_W) begin : g_fill_trunc
    assign w_fill = w_inv_ptr[DATA_W-1:0];
  end else begin : g_fill_ext
    assign w_fill = {{(DATA_W-ADDR_W){1'b0}}, w_inv_ptr};
  end

  assign w_last = (r_wr_ptr == '1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_wr_ptr;
    w_done_nxt  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = w_fill;
    busy        = 1'b0;
    wr_ready    = 1'b0;
    case (r_state)
      S_INIT: begin
        busy      = 1'b1;
        w_mem_we  = 1'b1;
        w_ptr_nxt = r_wr_ptr + ADDR_W'(1);
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_IDLE: begin
        wr_ready = 1'b1;
        // start retracts a coinciding write even though wr_ready is high.
        if (start) begin
          w_state_nxt = S_INIT;
          w_ptr_nxt   = '0;
        end else if (wr_valid) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = wr_data;
          w_ptr_nxt   = r_wr_ptr + ADDR_W'(1);
          w_done_nxt  = w_last;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_INIT;
      r_wr_ptr <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_ptr_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_mem[rd_address];
    end
  end

  // Contents survive reset; the INIT fill rewrites them.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      r_mem[r_wr_ptr] <= w_mem_wdata;
    end
  end

  assign done   = r_done;
  assign wr_ptr = r_wr_ptr;

endmodule

// File: doc/table_writer.md
Name: table_writer

Overview:
Write-side counterpart to the team's 16x4 lookup ROM: a 16-entry x 4-bit synchronous table with a streaming write port, plus a registered read port that has the same address-to-data meaning as the ROM. After reset the block self-initialises every entry to the ROM's default pattern (data = bitwise NOT of address). A producer can then overwrite entries in sequential order through a valid/ready handshake. Downstream lookup logic reads through rd_address/rd_data.

Parameters:
ADDR_W, 4, address width; depth = 2**ADDR_W entries
DATA_W, 4, data word width; default fill value is ~address truncated/zero-extended to DATA_W

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to re-run default fill; honoured only in IDLE
wr_valid  input  1  producer has a word on wr_data
wr_data  input  DATA_W  word to write at current write pointer
wr_ready  output  1  block accepts a word this cycle
rd_address  input  ADDR_W  read address
rd_data  output  DATA_W  registered read data
busy  output  1  high during INIT fill
done  output  1  one-cycle pulse: INIT finished, or a LOAD pass wrote the last entry
wr_ptr  output  ADDR_W  next entry to be written

Behaviour:
- Reset values, applied on the cycle reset is sampled high:
  - state=INIT, wr_ptr=0, rd_data=0, done=0, busy=1, wr_ready=0.
  - Table contents are not cleared by reset. INIT overwrites them.
- INIT state:
  - Each cycle: mem[wr_ptr] <= ~wr_ptr (DATA_W bits), then wr_ptr increments.
  - After writing entry 2**ADDR_W-1: wr_ptr wraps to 0, state goes to IDLE, done pulses 1 on the following cycle.
  - INIT takes exactly 16 cycles at default parameters.
  - wr_ready=0 and busy=1 throughout INIT. wr_valid and start are ignored.
- IDLE state (also the LOAD behaviour; there is no separate state):
  - wr_ready=1 and busy=0.
  - Transfer occurs when wr_valid && wr_ready: mem[wr_ptr] <= wr_data, wr_ptr increments.
  - Writing entry 15 wraps wr_ptr to 0 and pulses done 1 on the next cycle.
  - wr_valid=0 leaves wr_ptr unchanged. Writes are back-to-back capable, one per cycle.
- start in IDLE:
  - Next state is INIT, wr_ptr forced to 0, wr_ready drops next cycle.
  - If start and a valid write coincide, start wins: the write is NOT performed, even though wr_ready was 1 that cycle. The producer must treat start as a retraction.
- Read port:
  - rd_data <= mem[rd_address] every cycle in all states except reset. Latency is 1 cycle.
  - Same-cycle read and write to the same address returns the OLD contents (read-before-write). The new value is visible one cycle later.
  - Reads during INIT return whatever the entry holds at that edge.
- done:
  - Pulses exactly one cycle per completion event. Never high two cycles in a row unless two completion events occur back to back.
  - Back-to-back completions cannot happen at depth 16.
- Reset mid-INIT or mid-load: restarts INIT from entry 0. Entries already written are overwritten by the fill.
- State encoding is 1 bit (INIT/IDLE). wr_ptr is an ADDR_W-bit counter with natural wrap; no arithmetic wider than ADDR_W.

Test Plan:
1. Reset for 2 cycles, release, wait for done. Then read addresses 0..15 -> busy high for exactly 16 cycles after reset release, done pulses once, rd_data one cycle after each address equals 15,14,...,0.
2. After init, stream 16 words 0x3,0x5,... with wr_valid held high. Read back -> wr_ready=1 throughout, wr_ptr 0..15 then 0, done pulses one cycle after the 16th write, readback matches the written words.
3. Write 0xA to address 4 while rd_address=4 in the same cycle -> rd_data shows old value (0xB) next cycle and 0xA the cycle after.
4. Gapped writes (wr_valid toggling) -> wr_ptr advances only on valid cycles, no done until the 16th accepted word.
5. In IDLE with wr_ptr=7, assert start and wr_valid together with wr_data=0x0 -> entry 7 keeps its prior value, busy rises next cycle, full default pattern restored, done pulses at end.
6. Assert reset at INIT entry 9 -> wr_ptr=0 and busy=1 next cycle, fill restarts, done pulses once after 16 more cycles.
